// File: rtl/shift_add_multiplier_4_bit.sv
// shift_add_multiplier_4_bit
//   Sequential 4x4 unsigned multiplier. A single 4-bit adder is reused once
//   per clock across a fixed 4-iteration shift-and-add sequence.
//
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     start    operation request, sampled only while idle
//     a        multiplicand (captured when start is accepted)
//     b        multiplier   (captured when start is accepted)
//     busy     high while the iterations are running
//     done     one-cycle completion pulse
//     product  registered 8-bit result, held until the next completion
//
// full_adder_4_bit
//   4-bit adder stage providing sum and carry-out.
//
//   Ports:
//     a, b     4-bit addends
//     cin      carry in
//     sum      4-bit sum
//     cout     carry out

module full_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module shift_add_multiplier_4_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] m;
    logic [3:0] acc;
    logic [3:0] q;
    logic [1:0] count;

    logic [3:0] addend;
    logic [3:0] s;
    logic       c;
    logic [3:0] acc_next;
    logic [3:0] q_next;

    // Add M only when the current multiplier LSB is set.
    assign addend = q[0] ? m : '0;

    full_adder_4_bit u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    // Right shift of {C, S, Q}: the carry lands in the top accumulator bit,
    // so it is never lost, and the sum LSB moves into Q.
    assign acc_next = {c, s[3:1]};
    assign q_next   = {s[0], q[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + 2'd1;
                    if (count == 2'd3) begin
                        product <= {acc_next, q_next};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_4_bit.sv
module tb_shift_add_multiplier_4_bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] last_prod = '0;
    int         rem = 0;   // cycles left in the current operation (0 = idle)

    shift_add_multiplier_4_bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: an accepted start yields a*b after 4 busy cycles and 1 done cycle.
    always @(posedge clk) begin
        if (rst_n) begin
            if (rem == 0 && start === 1'b1) begin
                exp_q.push_back({4'b0000, a} * {4'b0000, b});
                rem = 5;
            end else if (rem > 0) begin
                rem--;
            end
        end
        #1;
        check("busy", {7'd0, busy}, {7'd0, (rem >= 2)});
        check("done", {7'd0, done}, {7'd0, (rem == 1)});
        check("busy_done_overlap", {7'd0, busy & done}, 8'd0);
        if (rem == 1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard_empty: done with no expected result at %0t", $time);
            end else begin
                last_prod = exp_q.pop_front();
            end
        end
        check("product", product, last_prod);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_product", product, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        pulse(4'd8, 4'd1);   idle(6);
        pulse(4'd15, 4'd15); idle(6);
        pulse(4'd11, 4'd10); idle(6);
        pulse(4'd0, 4'd13);  idle(6);

        // start during CALC is ignored
        pulse(4'd6, 4'd3);
        @(negedge clk);
        a = 4'd14; b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(6);

        // start held high: back-to-back operations every 6 cycles
        @(negedge clk);
        a = 4'd2; b = 4'd7; start = 1'b1;
        idle(18);
        start = 1'b0;
        idle(6);

        // asynchronous reset in the 2nd CALC cycle
        pulse(4'd14, 4'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rem = 0;
        exp_q.delete();
        last_prod = '0;
        #1;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        check("abort_product", product, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        // randomized traffic, including stray starts while busy
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            start = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        idle(8);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
